// File: rtl/reduction_call_responder_pkg.sv
`default_nettype none
// ============================================================================
// reduction_call_responder_pkg : opcodes, FSM states and chunk-count helper
// Revision: 1.0
// ============================================================================
package reduction_call_responder_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic int nchunk(input int data_w, input int chunk_w);
    return (data_w + chunk_w - 1) / chunk_w;
  endfunction

  function automatic logic is_and_class(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_NAND);
  endfunction

  function automatic logic is_or_class(input logic [2:0] op);
    return (op == OP_OR) || (op == OP_NOR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reduction_call_responder_chunk.sv
`default_nettype none
// ============================================================================
// reduction_chunk : folds one CHUNK_W-bit slice into the running accumulator
// Revision: 1.0
// ============================================================================
module reduction_chunk
  import reduction_call_responder_pkg::*;
#(
  parameter int CHUNK_W = 8
) (
  input  logic [2:0]         op_i,
  input  logic [CHUNK_W-1:0] chunk_i,
  input  logic [CHUNK_W-1:0] mask_i,
  input  logic               acc_i,
  output logic               acc_o
);

  logic [CHUNK_W-1:0] padded_w;

  // Bits beyond the operand take the identity value so they cannot sway the fold
  always_comb begin
    padded_w = chunk_i & mask_i;
    acc_o    = acc_i ^ (^padded_w);
    if (is_and_class(op_i)) begin
      padded_w = chunk_i | ~mask_i;
      acc_o    = acc_i & (&padded_w);
    end else if (is_or_class(op_i)) begin
      acc_o    = acc_i | (|padded_w);
    end
  end

endmodule
`default_nettype wire

// File: rtl/reduction_call_responder.sv
`default_nettype none
// ============================================================================
// reduction_call_responder : serial unary-reduction callee, one call in flight
// Revision: 1.0
// ============================================================================
module reduction_call_responder
  import reduction_call_responder_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_result,
  output logic              rsp_err,
  output logic [TAG_W-1:0]  rsp_tag
);

  localparam int NCHUNK = nchunk(DATA_W, CHUNK_W);
  localparam int PAD_W  = NCHUNK * CHUNK_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PAD_W-1:0]   data_q, data_d;
  logic [2:0]         op_q, op_d;
  logic               acc_q, acc_d;
  logic               result_q, result_d;
  logic               err_q, err_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  logic [CHUNK_W-1:0] mask_w;
  logic               acc_nxt_w;
  logic               last_w;

  always_comb begin
    mask_w = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      mask_w[i] = ((int'(cnt_q) * CHUNK_W + i) < DATA_W);
    end
  end

  reduction_chunk #(
    .CHUNK_W (CHUNK_W)
  ) u_chunk (
    .op_i    (op_q),
    .chunk_i (data_q[CHUNK_W-1:0]),
    .mask_i  (mask_w),
    .acc_i   (acc_q),
    .acc_o   (acc_nxt_w)
  );

  assign last_w     = (cnt_q == CNT_W'(NCHUNK - 1));
  assign req_ready  = (state_q == S_IDLE) && !reset;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign rsp_tag    = tag_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    op_d     = op_q;
    acc_d    = acc_q;
    result_d = result_q;
    err_d    = err_q;
    tag_d    = tag_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d   = req_op;
          data_d = PAD_W'(req_data);
          tag_d  = req_tag;
          cnt_d  = '0;
          if (req_op <= OP_XNOR) begin
            acc_d   = is_and_class(req_op);
            err_d   = 1'b0;
            state_d = S_RUN;
          end else begin
            err_d    = 1'b1;
            result_d = 1'b0;
            state_d  = S_RESP;
          end
        end
      end
      S_RUN: begin
        acc_d  = acc_nxt_w;
        data_d = data_q >> CHUNK_W;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_w) begin
          // Odd opcodes are the inverted forms
          result_d = acc_nxt_w ^ op_q[0];
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      op_q     <= '0;
      acc_q    <= 1'b0;
      result_q <= 1'b0;
      err_q    <= 1'b0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      err_q    <= err_d;
      tag_q    <= tag_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reduction_call_responder.sv
`default_nettype none
// ============================================================================
// tb_reduction_call_responder : directed and random calls on 32- and 12-bit DUTs
// Revision: 1.0
// ============================================================================
module tb_reduction_call_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req_op = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_tag = '0;

  logic        rv32 = 1'b0, rr32 = 1'b0;
  logic        rqr32, sv32, res32, err32;
  logic [3:0]  tag32;
  logic        rv12 = 1'b0, rr12 = 1'b0;
  logic        rqr12, sv12, res12, err12;
  logic [3:0]  tag12;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reduction_call_responder #(.DATA_W(32), .CHUNK_W(8), .TAG_W(4)) u_d32 (
    .clk(clk), .reset(reset), .req_valid(rv32), .req_ready(rqr32),
    .req_op(req_op), .req_data(req_data), .req_tag(req_tag),
    .rsp_valid(sv32), .rsp_ready(rr32), .rsp_result(res32),
    .rsp_err(err32), .rsp_tag(tag32)
  );

  reduction_call_responder #(.DATA_W(12), .CHUNK_W(8), .TAG_W(4)) u_d12 (
    .clk(clk), .reset(reset), .req_valid(rv12), .req_ready(rqr12),
    .req_op(req_op), .req_data(req_data[11:0]), .req_tag(req_tag),
    .rsp_valid(sv12), .rsp_ready(rr12), .rsp_result(res12),
    .rsp_err(err12), .rsp_tag(tag12)
  );

  // Reference: reduction defined by counting ones in the operand
  function automatic logic model(input logic [2:0] op, input logic [31:0] d, input int w);
    logic [63:0] m;
    int   ones;
    logic r;
    m    = {32'd0, d} & ((64'd1 << w) - 64'd1);
    ones = $countones(m);
    case (op)
      3'd0, 3'd1: r = (ones == w);
      3'd2, 3'd3: r = (ones != 0);
      default:    r = ones[0];
    endcase
    return (op == 3'd1 || op == 3'd3 || op == 3'd5) ? ~r : r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic f_rqr(input int s); return s != 0 ? rqr12 : rqr32; endfunction
  function automatic logic f_sv(input int s);  return s != 0 ? sv12 : sv32; endfunction
  function automatic logic f_res(input int s); return s != 0 ? res12 : res32; endfunction
  function automatic logic f_err(input int s); return s != 0 ? err12 : err32; endfunction
  function automatic logic [3:0] f_tag(input int s); return s != 0 ? tag12 : tag32; endfunction

  task automatic set_rv(input int s, input logic v);
    if (s != 0) rv12 = v; else rv32 = v;
  endtask

  task automatic set_rr(input int s, input logic v);
    if (s != 0) rr12 = v; else rr32 = v;
  endtask

  task automatic accept(input int s, input logic [2:0] op, input logic [31:0] d, input logic [3:0] t);
    int n;
    n = 0;
    while (!f_rqr(s) && n < 50) begin
      tick();
      n++;
    end
    check("req_ready_before_accept", 32'(f_rqr(s)), 32'd1);
    req_op   = op;
    req_data = d;
    req_tag  = t;
    set_rv(s, 1'b1);
    tick();
    set_rv(s, 1'b0);
    req_op   = 3'($urandom);
    req_data = $urandom;
    req_tag  = 4'($urandom);
  endtask

  task automatic await_rsp(input int s, input int exp_lat);
    int lat;
    lat = 1;
    while (!f_sv(s) && lat < 50) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic respond(input int s, input logic er, input logic ee, input logic [3:0] et, input int hold);
    check("rsp_valid", 32'(f_sv(s)), 32'd1);
    check("rsp_result", 32'(f_res(s)), 32'(er));
    check("rsp_err", 32'(f_err(s)), 32'(ee));
    check("rsp_tag", 32'(f_tag(s)), 32'(et));
    check("req_ready_in_resp", 32'(f_rqr(s)), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_stable", {27'd0, f_sv(s), f_res(s), f_err(s), f_tag(s) == et, f_rqr(s)},
            {27'd0, 1'b1, er, ee, 1'b1, 1'b0});
    end
    set_rr(s, 1'b1);
    tick();
    set_rr(s, 1'b0);
    check("rsp_valid_drop", 32'(f_sv(s)), 32'd0);
  endtask

  task automatic call(input int s, input logic [2:0] op, input logic [31:0] d, input logic [3:0] t, input int hold);
    int w;
    w = (s != 0) ? 12 : 32;
    accept(s, op, d, t);
    if (op > 3'd5) begin
      await_rsp(s, 1);
      respond(s, 1'b0, 1'b1, t, hold);
    end else begin
      await_rsp(s, (s != 0) ? 3 : 5);
      respond(s, model(op, d, w), 1'b0, t, hold);
    end
  endtask

  initial begin
    logic seen;
    repeat (2) tick();
    check("rst_rsp_valid", 32'(sv32), 32'd0);
    check("rst_result", 32'(res32), 32'd0);
    check("rst_err", 32'(err32), 32'd0);
    check("rst_tag", 32'(tag32), 32'd0);
    check("rst_req_ready", 32'(rqr32), 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_req_ready", 32'(rqr32), 32'd1);

    call(0, 3'd0, 32'hFFFF_FFFF, 4'd3, 0);
    call(0, 3'd0, 32'hFFFF_FFFE, 4'd1, 0);
    call(0, 3'd2, 32'h0000_0000, 4'd2, 1);
    call(0, 3'd2, 32'h8000_0000, 4'd4, 0);
    call(0, 3'd4, 32'h0000_0007, 4'd5, 0);
    call(0, 3'd5, 32'h0000_0007, 4'd6, 2);

    call(1, 3'd0, 32'h0000_0FFF, 4'd7, 0);
    call(1, 3'd1, 32'h0000_0FFF, 4'd8, 0);
    call(1, 3'd4, 32'h0000_0800, 4'd9, 0);
    call(1, 3'd0, 32'hFFFF_F7FF, 4'd10, 0);

    call(0, 3'd6, 32'h1234_5678, 4'd9, 0);
    call(0, 3'd7, 32'h0, 4'd12, 1);

    // Request held through a stalled response is taken only from IDLE
    accept(0, 3'd2, 32'h0000_0001, 4'd5);
    req_op   = 3'd4;
    req_data = 32'h0000_0007;
    req_tag  = 4'd6;
    rv32     = 1'b1;
    await_rsp(0, 5);
    respond(0, 1'b1, 1'b0, 4'd5, 10);
    check("idle_after_handshake", 32'(rqr32), 32'd1);
    tick();
    rv32 = 1'b0;
    await_rsp(0, 5);
    respond(0, 1'b1, 1'b0, 4'd6, 0);

    // Reset mid-call drops the call entirely
    accept(0, 3'd0, 32'hFFFF_FFFF, 4'd2);
    tick();
    reset = 1'b1;
    tick();
    check("rst_run_req_ready", 32'(rqr32), 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (sv32) seen = 1'b1;
    end
    check("aborted_no_rsp", 32'(seen), 32'd0);
    call(0, 3'd2, 32'h0000_0010, 4'd11, 0);

    for (int i = 0; i < 24; i++) begin
      call(i % 3 == 2 ? 1 : 0, 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
           4'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
